// File: rtl/onchip_memory_pkg.sv
// onchip_memory_pkg: FSM state type and default parameters shared by the on-chip memory block
package onchip_memory_pkg;
    typedef enum logic {CLEAR, READY} state_t;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_ADDR_W         = 10;
    localparam int DEF_READ_LATENCY   = 1;
    localparam int DEF_CLEAR_ON_RESET = 1;
    localparam int BE_W               = DEF_DATA_W / 8;
endpackage

// File: rtl/onchip_ram_core.sv
// onchip_ram_core: single-port byte-enabled RAM with a registered read port (latency 1)
//   clk, reset_n : clock and async active-low reset (read register only; array is never reset)
//   en           : clock enable for both write and read
//   we, be       : write strobe and per-byte write mask
//   re           : read strobe; rdata holds its value when re is low
//   addr, wdata  : word address and write data
//   rdata        : registered read data
module onchip_ram_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                we,
    input  logic                re,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (en && we)
            for (int i = 0; i < DATA_W / 8; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rdata <= '0;
        else if (en && re) rdata <= mem[addr];
endmodule

// File: rtl/onchip_memory_pipelined.sv
// onchip_memory_pipelined: Avalon-style on-chip memory with optional zero-fill and 1/2-cycle read latency
//   clk, reset_n        : clock, async active-low reset
//   address, byteenable : word address and byte write mask
//   chipselect, read, write, writedata : request interface (write wins over read)
//   clken               : clock enable; low freezes the whole block
//   readdata, readdatavalid : read response, valid for one enabled cycle
//   waitrequest         : request not accepted this cycle
//   init_done           : zero-fill finished
module onchip_memory_pipelined
    import onchip_memory_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int READ_LATENCY   = DEF_READ_LATENCY,
    parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                init_done
);
    localparam state_t              INIT_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    localparam logic [ADDR_W-1:0]   LAST_ADDR  = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                clearing, rd_acc, wr_acc, v1_q, v2_q;
    logic [DATA_W-1:0]   ram_rdata, rd2_q;

    // Reset is folded in combinationally so the outputs react the instant reset_n falls.
    assign clearing    = reset_n & (state_q == CLEAR);
    assign waitrequest = ~reset_n | (state_q != READY) | ~clken;
    assign init_done   = reset_n & (state_q == READY);
    assign wr_acc      = chipselect & write & ~waitrequest;
    assign rd_acc      = chipselect & read & ~write & ~waitrequest;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clearing) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) state_d = READY;
        end
    end

    // Everything advances only on enabled edges, so a stall never loses an in-flight read.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= INIT_STATE;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            rd2_q   <= '0;
        end else if (clken) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v1_q    <= rd_acc;
            v2_q    <= v1_q;
            if (v1_q) rd2_q <= ram_rdata;
        end

    // The fill sequence borrows the single RAM port while no requests are accepted.
    onchip_ram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (clken),
        .we     (clearing | wr_acc),
        .re     (rd_acc),
        .be     (clearing ? '1 : byteenable),
        .addr   (clearing ? cnt_q : address),
        .wdata  (clearing ? '0 : writedata),
        .rdata  (ram_rdata)
    );

    assign readdata      = (READ_LATENCY == 2) ? rd2_q : ram_rdata;
    assign readdatavalid = (READ_LATENCY == 2) ? v2_q : v1_q;
endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// tb_onchip_memory_pipelined: checks latency-1 and latency-2 instances against a cycle-history model
module tb_onchip_memory_pipelined;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [3:0]  address = '0, byteenable = '0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0, clken = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] rd1, rd2;
    logic        v1, v2, w1, w2, i1, i2;

    always #5 clk = ~clk;

    onchip_memory_pipelined #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) d1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .readdata(rd1), .readdatavalid(v1), .waitrequest(w1), .init_done(i1));

    onchip_memory_pipelined #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) d2 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .readdata(rd2), .readdatavalid(v2), .waitrequest(w2), .init_done(i2));

    int checks = 0, failures = 0;

    // Model: memory array, fill progress, and one history entry per enabled edge.
    logic [31:0] mem [16];
    bit          m_ready;
    int          m_cnt;
    bit          hv [$];
    logic [31:0] hd [$];
    bit          ev [3];
    logic [31:0] ed [3];

    typedef struct {
        logic        cs, rd, wr;
        logic [3:0]  a, be;
        logic [31:0] wd;
        logic        ev;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mk(logic cs, logic rd, logic wr, logic [3:0] a, logic [3:0] be,
                                logic [31:0] wd, logic e_v, logic [31:0] e_d);
        vec_t v;
        v.cs = cs; v.rd = rd; v.wr = wr; v.a = a; v.be = be; v.wd = wd; v.ev = e_v; v.ed = e_d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_ready = 1'b0;
        m_cnt   = 0;
        hv.delete();
        hd.delete();
        for (int l = 0; l < 3; l++) begin
            ev[l] = 1'b0;
            ed[l] = '0;
        end
    endtask

    task automatic model_edge();
        if (!reset_n || !clken) return;
        if (!m_ready) begin
            mem[m_cnt] = '0;
            m_cnt++;
            m_ready = (m_cnt == 16);
            hv.push_back(1'b0);
            hd.push_back('0);
        end else begin
            hv.push_back(chipselect && read && !write);
            hd.push_back(mem[address]);
            if (chipselect && write)
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) mem[address][8*b +: 8] = writedata[8*b +: 8];
        end
        // A response for latency L appears L-1 enabled edges after acceptance.
        for (int l = 1; l <= 2; l++) begin
            ev[l] = (hv.size() >= l) && hv[hv.size() - l];
            if (ev[l]) ed[l] = hd[hv.size() - l];
        end
    endtask

    task automatic model_check();
        logic ew;
        ew = !(reset_n && m_ready && clken);
        chk("wait_rl1", 32'(w1), 32'(ew));
        chk("wait_rl2", 32'(w2), 32'(ew));
        chk("init_rl1", 32'(i1), 32'(reset_n && m_ready));
        chk("init_rl2", 32'(i2), 32'(reset_n && m_ready));
        chk("valid_rl1", 32'(v1), 32'(ev[1]));
        chk("valid_rl2", 32'(v2), 32'(ev[2]));
        chk("data_rl1", rd1, ed[1]);
        chk("data_rl2", rd2, ed[2]);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic set_in(input logic cs, input logic rd, input logic wr, input logic [3:0] a,
                          input logic [3:0] be, input logic [31:0] wd, input logic ce);
        chipselect = cs; read = rd; write = wr; address = a; byteenable = be; writedata = wd; clken = ce;
    endtask

    task automatic reset_now();
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("rst_data_rl1", rd1, 32'h0);
        chk("rst_data_rl2", rd2, 32'h0);
        chk("rst_valid", 32'({v1, v2}), 32'h0);
        chk("rst_wait", 32'({w1, w2}), 32'h3);
        chk("rst_init", 32'({i1, i2}), 32'h0);
    endtask

    task automatic fill_and_count();
        int n;
        n = 0;
        reset_n = 1'b1;
        while (!i1 && n < 100) begin
            cyc();
            n++;
        end
        chk("fill_cycles", 32'(n), 32'd16);
    endtask

    initial begin
        m_reset();
        repeat (2) cyc();
        fill_and_count();
        for (int a = 0; a < 16; a++) begin
            set_in(1, 1, 0, 4'(a), 4'h0, '0, 1);
            cyc();
            chk("fill_zero", rd1, 32'h0);
        end
        set_in(0, 0, 0, 0, 0, '0, 1);
        cyc();

        tbl.push_back(mk(1, 0, 1, 3, 4'hF, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(1, 0, 1, 3, 4'h5, 32'h11223344, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3, 4'h0, 32'h0, 1, 32'hDE22BE44));
        tbl.push_back(mk(1, 1, 1, 5, 4'hF, 32'h00000055, 0, 0));
        tbl.push_back(mk(1, 1, 0, 5, 4'h0, 32'h0, 1, 32'h00000055));
        tbl.push_back(mk(1, 0, 1, 7, 4'h0, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(1, 1, 0, 7, 4'h0, 32'h0, 1, 32'h00000000));
        tbl.push_back(mk(0, 1, 0, 3, 4'h0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 9, 4'h8, 32'hCAFEF00D, 0, 0));
        tbl.push_back(mk(1, 1, 0, 9, 4'h0, 32'h0, 1, 32'hCA000000));
        tbl.push_back(mk(1, 0, 1, 2, 4'hF, 32'h12345678, 0, 0));
        tbl.push_back(mk(1, 1, 0, 2, 4'h0, 32'h0, 1, 32'h12345678));
        foreach (tbl[i]) begin
            set_in(tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].wd, 1);
            cyc();
            chk($sformatf("tbl%0d_valid", i), 32'(v1), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), rd1, tbl[i].ed);
        end

        // Latency-2 back-to-back reads
        for (int a = 0; a < 3; a++) begin
            set_in(1, 0, 1, 4'(a), 4'hF, 32'hA0 + 32'(a), 1);
            cyc();
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 3) set_in(1, 1, 0, 4'(k), 4'h0, '0, 1);
            else set_in(0, 0, 0, 0, 0, '0, 1);
            cyc();
            chk($sformatf("rl2_burst%0d_valid", k), 32'(v2), 32'(k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) chk($sformatf("rl2_burst%0d_data", k), rd2, 32'hA0 + 32'(k - 1));
        end

        // Three-cycle stall with one latency-2 read in flight
        set_in(1, 1, 0, 1, 4'h0, '0, 1);
        cyc();
        chk("stall_pre_valid", 32'(v2), 32'h0);
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 0, 2, 4'h0, '0, 0);
            cyc();
            chk("stall_valid", 32'(v2), 32'h0);
            chk("stall_wait", 32'({w1, w2}), 32'h3);
        end
        set_in(0, 0, 0, 0, 0, '0, 1);
        cyc();
        chk("stall_resume_valid", 32'(v2), 32'h1);
        chk("stall_resume_data", rd2, 32'hA1);
        cyc();
        chk("stall_after_valid", 32'(v2), 32'h0);

        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
                   $urandom_range(0, 4) != 0);
            cyc();
        end

        // Reset mid-fill at clear address 7 restarts the fill from 0
        set_in(0, 0, 0, 0, 0, '0, 1);
        reset_now();
        cyc();
        reset_n = 1'b1;
        repeat (7) cyc();
        chk("mid_fill_busy", 32'(i1), 32'h0);
        reset_now();
        cyc();
        fill_and_count();
        for (int a = 0; a < 16; a++) begin
            set_in(1, 1, 0, 4'(a), 4'h0, '0, 1);
            cyc();
        end
        set_in(0, 0, 0, 0, 0, '0, 1);
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
